// File: rtl/pwm_timer_regs.sv
// pwm_timer_regs: register-mapped PWM/timer peripheral.
// Reads a flat bank of config bytes and returns a flat bank of status bytes.
// Drives one PWM pin and one level interrupt.
// Every status byte is a flop or a constant, so no config-to-status
// combinational path exists.
module pwm_timer_regs #(
  parameter int           NUM_CFG    = 8,
  parameter int           NUM_STATUS = 8,
  parameter int           REG_WIDTH  = 8,
  parameter logic [7:0]   BLOCK_ID   = 8'hB1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ena,
  input  logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  output logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic                            pwm_out,
  output logic                            irq
);

  logic [REG_WIDTH-1:0] cfg_b [NUM_CFG];
  logic [REG_WIDTH-1:0] st_b  [NUM_STATUS];

  for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
    assign cfg_b[gi] = config_regs[gi*REG_WIDTH +: REG_WIDTH];
  end

  // Config field decode
  logic        cfg_en, cfg_oneshot, cfg_inv, cfg_clr, cfg_ie;
  logic [7:0]  cfg_presc;
  logic [15:0] cfg_period, cfg_duty;
  assign cfg_en      = cfg_b[0][0];
  assign cfg_oneshot = cfg_b[0][1];
  assign cfg_inv     = cfg_b[0][2];
  assign cfg_clr     = cfg_b[0][3];
  assign cfg_ie      = cfg_b[0][4];
  assign cfg_presc   = cfg_b[1];
  assign cfg_period  = {cfg_b[3], cfg_b[2]};
  assign cfg_duty    = {cfg_b[5], cfg_b[4]};

  logic unused_cfg;
  assign unused_cfg = ^{cfg_b[6], cfg_b[7], cfg_b[0][7:5]};

  // State
  logic        en_q, en_d, clr_q, clr_d, armed_q, armed_d;
  logic        running_q, running_d, done_q, done_d, wrap_flag_q, wrap_flag_d;
  logic [7:0]  wrap_cnt_q, wrap_cnt_d, presc_cnt_q, presc_cnt_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  presc_sh_q, presc_sh_d;
  logic [15:0] period_sh_q, period_sh_d, duty_sh_q, duty_sh_d;
  logic        pwm_q, pwm_d, irq_q, irq_d;

  // armed_q is clear for the first enabled cycle after reset.
  // It keeps an EN held high through reset from looking like a fresh rising edge.
  logic en_rise, clr_rise, tick, pwm_raw;
  assign en_rise  = cfg_en  & ~en_q  & armed_q;
  assign clr_rise = cfg_clr & ~clr_q & armed_q;
  assign tick     = running_q & (presc_cnt_q == presc_sh_q);
  assign pwm_raw  = running_q & (count_q < duty_sh_q);

  // Next-state: edge detect, start/stop, prescaler, counter, flags, outputs
  always_comb begin
    en_d        = en_q;
    clr_d       = clr_q;
    armed_d     = armed_q;
    running_d   = running_q;
    done_d      = done_q;
    wrap_flag_d = wrap_flag_q;
    wrap_cnt_d  = wrap_cnt_q;
    presc_cnt_d = presc_cnt_q;
    count_d     = count_q;
    presc_sh_d  = presc_sh_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    pwm_d       = pwm_q;
    irq_d       = irq_q;
    if (ena) begin
      en_d    = cfg_en;
      clr_d   = cfg_clr;
      armed_d = 1'b1;
      pwm_d   = pwm_raw ^ cfg_inv;
      irq_d   = (wrap_flag_q | done_q) & cfg_ie;
      if (clr_rise) begin
        wrap_flag_d = 1'b0;
        done_d      = 1'b0;
        wrap_cnt_d  = 8'h00;
      end
      if (en_rise) begin
        // A start wins over any tick that lands in the same cycle.
        running_d   = 1'b1;
        count_d     = 16'h0000;
        presc_cnt_d = 8'h00;
        done_d      = 1'b0;
        presc_sh_d  = cfg_presc;
        period_sh_d = cfg_period;
        duty_sh_d   = cfg_duty;
      end else if (running_q) begin
        if (!cfg_en) begin
          running_d = 1'b0;
        end else if (tick) begin
          presc_cnt_d = 8'h00;
          if (count_q == period_sh_q) begin
            // A wrap in the same cycle as a clear wins, so the event is not lost.
            count_d     = 16'h0000;
            presc_sh_d  = cfg_presc;
            period_sh_d = cfg_period;
            duty_sh_d   = cfg_duty;
            wrap_flag_d = 1'b1;
            if (clr_rise)
              wrap_cnt_d = 8'h01;
            else if (wrap_cnt_q != 8'hFF)
              wrap_cnt_d = wrap_cnt_q + 8'h01;
            if (cfg_oneshot) begin
              running_d = 1'b0;
              done_d    = 1'b1;
            end
          end else begin
            count_d = count_q + 16'h0001;
          end
        end else begin
          presc_cnt_d = presc_cnt_q + 8'h01;
        end
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q        <= 1'b0;
      clr_q       <= 1'b0;
      armed_q     <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      wrap_flag_q <= 1'b0;
      wrap_cnt_q  <= 8'h00;
      presc_cnt_q <= 8'h00;
      count_q     <= 16'h0000;
      presc_sh_q  <= 8'h00;
      period_sh_q <= 16'h0000;
      duty_sh_q   <= 16'h0000;
      pwm_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      en_q        <= en_d;
      clr_q       <= clr_d;
      armed_q     <= armed_d;
      running_q   <= running_d;
      done_q      <= done_d;
      wrap_flag_q <= wrap_flag_d;
      wrap_cnt_q  <= wrap_cnt_d;
      presc_cnt_q <= presc_cnt_d;
      count_q     <= count_d;
      presc_sh_q  <= presc_sh_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      pwm_q       <= pwm_d;
      irq_q       <= irq_d;
    end
  end

  // Status byte map; bytes beyond the map read as zero
  always_comb begin
    for (int i = 0; i < NUM_STATUS; i++) st_b[i] = '0;
    st_b[0] = count_q[7:0];
    st_b[1] = count_q[15:8];
    st_b[2] = {5'b00000, done_q, wrap_flag_q, running_q};
    st_b[3] = wrap_cnt_q;
    st_b[4] = presc_sh_q;
    st_b[5] = 8'h00;
    st_b[6] = {7'b0000000, pwm_q};
    st_b[7] = BLOCK_ID;
  end

  for (genvar gi = 0; gi < NUM_STATUS; gi++) begin : g_st
    assign status_regs[gi*REG_WIDTH +: REG_WIDTH] = st_b[gi];
  end

  assign pwm_out = pwm_q;
  assign irq     = irq_q;

endmodule
